// File: rtl/access_pkg.sv
// Shared definitions for the access_control credential checker:
// data width, status codes, FSM state type and the default credential table.
// With ACCESS_PW_CHANGE_EN defined the table passwords become writable;
// DEFAULT_PWS then gives their reset values.
package access_pkg;

  localparam int DATA_W      = 16;
  localparam int MAX_ENTRIES = 16;

  // Status codes shown on the LCD/LED path
  localparam logic [2:0] STAT_IDLE     = 3'd0;
  localparam logic [2:0] STAT_ENTER_ID = 3'd1;
  localparam logic [2:0] STAT_ENTER_PW = 3'd2;
  localparam logic [2:0] STAT_CHECKING = 3'd3;
  localparam logic [2:0] STAT_GRANTED  = 3'd4;
  localparam logic [2:0] STAT_DENIED   = 3'd5;
  localparam logic [2:0] STAT_LOCKED   = 3'd6;
  localparam logic [2:0] STAT_NEW_PW   = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ENTER_ID = 3'd1,
    S_ENTER_PW = 3'd2,
    S_CHECK    = 3'd3,
    S_GRANT    = 3'd4,
    S_DENY     = 3'd5,
    S_LOCKED   = 3'd6,
    S_NEW_PW   = 3'd7
  } state_e;

  // Entries 0..3 are the real users; the rest only exist so NUM_USERS can grow to 16.
  localparam logic [DATA_W-1:0] DEFAULT_IDS [MAX_ENTRIES] = '{
    16'h1234, 16'hBEEF, 16'h0042, 16'h7777,
    16'hF004, 16'hF005, 16'hF006, 16'hF007,
    16'hF008, 16'hF009, 16'hF00A, 16'hF00B,
    16'hF00C, 16'hF00D, 16'hF00E, 16'hF00F
  };
  localparam logic [DATA_W-1:0] DEFAULT_PWS [MAX_ENTRIES] = '{
    16'h0001, 16'h0A0A, 16'h4242, 16'h0000,
    16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
    16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
    16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF
  };

  // Status code presented while the FSM sits in a given state
  function automatic logic [2:0] status_of(state_e s);
    logic [2:0] code;
    case (s)
      S_IDLE:     code = STAT_IDLE;
      S_ENTER_ID: code = STAT_ENTER_ID;
      S_ENTER_PW: code = STAT_ENTER_PW;
      S_CHECK:    code = STAT_CHECKING;
      S_GRANT:    code = STAT_GRANTED;
      S_DENY:     code = STAT_DENIED;
      S_LOCKED:   code = STAT_LOCKED;
      S_NEW_PW:   code = STAT_NEW_PW;
      default:    code = STAT_IDLE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/cred_table.sv
// Credential table: combinational indexed read of {id, pw}.
// Without ACCESS_PW_CHANGE_EN the table is a constant ROM; with it the
// passwords are registers reset to the package defaults and written
// through a single registered write port.
module cred_table
  import access_pkg::*;
#(
  parameter int NUM_USERS = 4,
  parameter int DATA_W    = access_pkg::DATA_W,
  localparam int IDX_W    = $clog2(NUM_USERS)
) (
`ifdef ACCESS_PW_CHANGE_EN
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wr_en,
  input  logic [IDX_W-1:0]  i_wr_idx,
  input  logic [DATA_W-1:0] i_wr_pw,
`endif
  input  logic [IDX_W-1:0]  i_rd_idx,
  output logic [DATA_W-1:0] o_rd_id,
  output logic [DATA_W-1:0] o_rd_pw
);

  assign o_rd_id = DATA_W'(DEFAULT_IDS[i_rd_idx]);

`ifdef ACCESS_PW_CHANGE_EN
  logic [DATA_W-1:0] r_pws [NUM_USERS];

  // Password storage: defaults at reset, overwritten by a password change
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_USERS; i++) r_pws[i] <= DATA_W'(DEFAULT_PWS[i]);
    end else if (i_wr_en) begin
      r_pws[i_wr_idx] <= i_wr_pw;
    end
  end

  assign o_rd_pw = r_pws[i_rd_idx];
`else
  assign o_rd_pw = DATA_W'(DEFAULT_PWS[i_rd_idx]);
`endif

endmodule

// File: rtl/access_control.sv
// access_control: collects a user ID and password from the switches, checks
// them against cred_table with a constant-time scan, pulses access_fb on a
// match, counts consecutive failures and enforces a timed lockout.
// Handshake: 'enter' is a one-cycle strobe; the switch value is taken on the
// edge where enter=1 and enable=1 in an entry state; enable=0 aborts and
// overrides a simultaneous enter (except during lockout, which always completes).
// Optional feature macro: ACCESS_PW_CHANGE_EN (password change via NEW_PW).
module access_control
  import access_pkg::*;
#(
  parameter int NUM_USERS   = 4,
  parameter int DATA_W      = access_pkg::DATA_W,
  parameter int MAX_TRIES   = 3,
  parameter int LOCK_CYCLES = 50000000,
  localparam int IDX_W      = $clog2(NUM_USERS),
  localparam int LOCK_W     = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              enter,
  input  logic              pw_change_req,
  input  logic [DATA_W-1:0] switches,
  output logic              access_fb,
  output logic [DATA_W-1:0] userid,
  output logic [IDX_W-1:0]  user_idx,
  output logic [2:0]        status,
  output logic [1:0]        fail_count
);

  state_e             r_state, w_next;
  logic [DATA_W-1:0]  r_id, r_pw;
  logic [IDX_W-1:0]   r_scan, r_match_idx;
  logic               r_found;
  logic [LOCK_W-1:0]  r_lock_cnt;
  logic               r_access_fb;
  logic [DATA_W-1:0]  r_userid;
  logic [IDX_W-1:0]   r_user_idx;
  logic [2:0]         r_status;
  logic [1:0]         r_fail_count;

  logic [DATA_W-1:0]  w_tbl_id, w_tbl_pw;
  logic               w_hit, w_scan_last, w_matched, w_want_chg;
  logic               w_lock_now, w_lock_done;
  logic [1:0]         w_fail_inc;
  logic               w_fb_d, w_load_user, w_fail_clr, w_fail_step;

`ifdef ACCESS_PW_CHANGE_EN
  logic               r_chg;
  logic               w_wr_en;
  assign w_want_chg = r_chg;
  assign w_wr_en    = (r_state == S_NEW_PW) && enable && enter;

  cred_table #(.NUM_USERS(NUM_USERS), .DATA_W(DATA_W)) u_table (
    .clk      (clk),
    .rst      (rst),
    .i_wr_en  (w_wr_en),
    .i_wr_idx (r_match_idx),
    .i_wr_pw  (switches),
    .i_rd_idx (r_scan),
    .o_rd_id  (w_tbl_id),
    .o_rd_pw  (w_tbl_pw)
  );
`else
  logic w_unused_chg;
  assign w_unused_chg = pw_change_req;
  assign w_want_chg   = 1'b0;

  cred_table #(.NUM_USERS(NUM_USERS), .DATA_W(DATA_W)) u_table (
    .i_rd_idx (r_scan),
    .o_rd_id  (w_tbl_id),
    .o_rd_pw  (w_tbl_pw)
  );
`endif

  assign w_hit       = (w_tbl_id == r_id) && (w_tbl_pw == r_pw);
  assign w_scan_last = (r_scan == IDX_W'(NUM_USERS - 1));
  assign w_matched   = r_found || w_hit;
  assign w_fail_inc  = r_fail_count + 2'd1;
  assign w_lock_now  = (w_fail_inc == 2'(MAX_TRIES));
  assign w_lock_done = (r_lock_cnt == '0);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic; abort on enable=0 everywhere except the lockout
  always_comb begin
    w_next = r_state;
    if (!enable && (r_state != S_LOCKED)) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:     w_next = S_ENTER_ID;
        S_ENTER_ID: if (enter) w_next = S_ENTER_PW;
        S_ENTER_PW: if (enter) w_next = S_CHECK;
        S_CHECK:    if (w_scan_last)
                      w_next = w_matched ? (w_want_chg ? S_NEW_PW : S_GRANT) : S_DENY;
        S_GRANT:    w_next = S_ENTER_ID;
        S_DENY:     w_next = w_lock_now ? S_LOCKED : S_ENTER_ID;
        S_LOCKED:   if (w_lock_done) w_next = enable ? S_ENTER_ID : S_IDLE;
        S_NEW_PW:   if (enter) w_next = S_GRANT;
        default:    w_next = S_IDLE;
      endcase
    end
  end

  // Output decode: what the registered outputs take on the coming edge
  always_comb begin
    w_fb_d      = (r_state == S_GRANT);
    w_load_user = (r_state == S_GRANT);
    w_fail_clr  = (r_state == S_GRANT) || ((r_state == S_LOCKED) && w_lock_done);
    w_fail_step = (r_state == S_DENY) && enable;
  end

  // Datapath: latched credentials, constant-time scan and lockout timer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_id        <= '0;
      r_pw        <= '0;
      r_scan      <= '0;
      r_found     <= 1'b0;
      r_match_idx <= '0;
      r_lock_cnt  <= '0;
`ifdef ACCESS_PW_CHANGE_EN
      r_chg       <= 1'b0;
`endif
    end else begin
      if (r_state == S_IDLE) begin
        r_id <= '0;
        r_pw <= '0;
      end
      if ((r_state == S_ENTER_ID) && enable && enter) r_id <= switches;
      if ((r_state == S_ENTER_PW) && enable && enter) begin
        r_pw  <= switches;
`ifdef ACCESS_PW_CHANGE_EN
        r_chg <= pw_change_req;
`endif
      end
      // Every entry is visited regardless of an early hit; the first hit wins
      if (r_state == S_CHECK) begin
        r_scan <= r_scan + IDX_W'(1);
        if (w_hit && !r_found) begin
          r_found     <= 1'b1;
          r_match_idx <= r_scan;
        end
      end else begin
        r_scan  <= '0;
        r_found <= 1'b0;
      end
      if ((r_state == S_DENY) && (w_next == S_LOCKED))
        r_lock_cnt <= LOCK_W'(LOCK_CYCLES - 1);
      else if ((r_state == S_LOCKED) && !w_lock_done)
        r_lock_cnt <= r_lock_cnt - LOCK_W'(1);
    end
  end

  // Registered outputs; status always mirrors the state being entered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_access_fb  <= 1'b0;
      r_userid     <= '0;
      r_user_idx   <= '0;
      r_status     <= STAT_IDLE;
      r_fail_count <= '0;
    end else begin
      r_access_fb <= w_fb_d;
      r_status    <= status_of(w_next);
      if (w_load_user) begin
        r_userid   <= r_id;
        r_user_idx <= r_match_idx;
      end
      if (w_fail_clr)       r_fail_count <= '0;
      else if (w_fail_step) r_fail_count <= w_fail_inc;
    end
  end

  assign access_fb  = r_access_fb;
  assign userid     = r_userid;
  assign user_idx   = r_user_idx;
  assign status     = r_status;
  assign fail_count = r_fail_count;

endmodule
